// File: rtl/dma_arb_pkg.sv
// Shared definitions for the weighted round-robin DMA arbiter: FSM state
// encoding, a constant clog2 and a one-hot to binary index helper.
package dma_arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } arb_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) begin
      r++;
    end
    return r;
  endfunction

  // Valid for one-hot or all-zero input; an all-zero vector maps to index 0.
  function automatic logic [4:0] onehot_to_idx(input logic [31:0] oh);
    logic [4:0] idx;
    idx = 5'd0;
    for (int i = 0; i < 32; i++) begin
      idx = idx | (oh[i] ? 5'(i) : 5'd0);
    end
    return idx;
  endfunction

endpackage

// File: rtl/dma_rr_pick.sv
// Combinational masked round-robin pick: lowest requester inside the mask,
// falling back to the lowest requester overall. Also returns the winner's mask.
module dma_rr_pick
  import dma_arb_pkg::*;
#(
  parameter int NO_OF_REQS = 4,
  parameter int IDX_WIDTH  = 2
) (
  input  logic [NO_OF_REQS-1:0] req,
  input  logic [NO_OF_REQS-1:0] mask,
  output logic [NO_OF_REQS-1:0] win,
  output logic [IDX_WIDTH-1:0]  win_idx,
  output logic [NO_OF_REQS-1:0] next_mask
);

  localparam logic [NO_OF_REQS-1:0] ONE = {{(NO_OF_REQS-1){1'b0}}, 1'b1};

  logic [NO_OF_REQS-1:0] masked_s;
  logic [NO_OF_REQS-1:0] pool_s;

  assign masked_s = req & mask;
  assign pool_s   = (|masked_s) ? masked_s : req;
  // Two's-complement trick isolates the lowest set bit.
  assign win      = pool_s & (~pool_s + ONE);
  assign win_idx  = IDX_WIDTH'(onehot_to_idx(32'(win)));
  // Bits strictly above the winner; empty when the winner is the top index.
  assign next_mask = ~({win[NO_OF_REQS-2:0], 1'b0} - ONE);

endmodule

// File: rtl/dma_weighted_rr_arbiter.sv
// Weighted round-robin arbiter with per-requester credits per tenure.
// Optional urgent class enabled by defining DMA_WRR_ARB_URGENT_EN.
module dma_weighted_rr_arbiter
  import dma_arb_pkg::*;
#(
  parameter int NO_OF_REQS   = 4,
  parameter int WEIGHT_WIDTH = 4,
  localparam int IDX_WIDTH   = (clog2(NO_OF_REQS) < 1) ? 1 : clog2(NO_OF_REQS)
) (
  input  logic                               clock,
  input  logic                               resetn,
  input  logic [NO_OF_REQS-1:0]              req,
  input  logic [NO_OF_REQS*WEIGHT_WIDTH-1:0] weights,
`ifdef DMA_WRR_ARB_URGENT_EN
  input  logic [NO_OF_REQS-1:0]              urgent,
`endif
  input  logic                               grantAck,
  output logic [NO_OF_REQS-1:0]              grant,
  output logic                               grantValid,
  output logic [IDX_WIDTH-1:0]               grantIdx,
  output logic                               grantLast
);

  localparam logic [WEIGHT_WIDTH-1:0] CREDIT_ONE = {{(WEIGHT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [NO_OF_REQS-1:0]   ALL_ONES   = {NO_OF_REQS{1'b1}};
  localparam logic [NO_OF_REQS-1:0]   NONE       = {NO_OF_REQS{1'b0}};

  arb_state_e              state_q, state_d;
  logic [NO_OF_REQS-1:0]   grant_q, grant_d;
  logic [NO_OF_REQS-1:0]   mask_q, mask_d;
  logic [NO_OF_REQS-1:0]   owner_mask_q, owner_mask_d;
  logic                    valid_q, valid_d;
  logic [IDX_WIDTH-1:0]    idx_q, idx_d;
  logic [WEIGHT_WIDTH-1:0] credit_q, credit_d;

  logic [WEIGHT_WIDTH-1:0] weight_s [NO_OF_REQS];
  logic                    in_grant_s;
  logic [NO_OF_REQS-1:0]   cand_s;
  logic [NO_OF_REQS-1:0]   pick_mask_s;
  logic [NO_OF_REQS-1:0]   norm_win_s, norm_mask_s;
  logic [IDX_WIDTH-1:0]    norm_idx_s;
  logic [NO_OF_REQS-1:0]   sel_win_s, sel_mask_s;
  logic [IDX_WIDTH-1:0]    sel_idx_s;
  logic                    preempt_s;
  logic                    owner_req_s;
  logic                    last_s;

  for (genvar g = 0; g < NO_OF_REQS; g++) begin : g_weight
    assign weight_s[g] = weights[g*WEIGHT_WIDTH +: WEIGHT_WIDTH];
  end

  function automatic logic [WEIGHT_WIDTH-1:0] fresh_credit(input logic [WEIGHT_WIDTH-1:0] w);
    return (w == {WEIGHT_WIDTH{1'b0}}) ? CREDIT_ONE : w;
  endfunction

  // While granted, candidates exclude the owner and use the mask the owner leaves behind.
  assign in_grant_s  = (state_q == ST_GRANT);
  assign cand_s      = in_grant_s ? (req & ~grant_q) : req;
  assign pick_mask_s = in_grant_s ? owner_mask_q : mask_q;
  assign owner_req_s = |(req & grant_q);

  dma_rr_pick #(
    .NO_OF_REQS(NO_OF_REQS),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_pick (
    .req      (cand_s),
    .mask     (pick_mask_s),
    .win      (norm_win_s),
    .win_idx  (norm_idx_s),
    .next_mask(norm_mask_s)
  );

`ifdef DMA_WRR_ARB_URGENT_EN
  logic [NO_OF_REQS-1:0] urg_win_s, urg_mask_s;
  logic [IDX_WIDTH-1:0]  urg_idx_s;

  dma_rr_pick #(
    .NO_OF_REQS(NO_OF_REQS),
    .IDX_WIDTH (IDX_WIDTH)
  ) u_pick_urgent (
    .req      (cand_s & urgent),
    .mask     (pick_mask_s),
    .win      (urg_win_s),
    .win_idx  (urg_idx_s),
    .next_mask(urg_mask_s)
  );

  assign sel_win_s  = (|urg_win_s) ? urg_win_s  : norm_win_s;
  assign sel_idx_s  = (|urg_win_s) ? urg_idx_s  : norm_idx_s;
  assign sel_mask_s = (|urg_win_s) ? urg_mask_s : norm_mask_s;
  assign preempt_s  = |(req & urgent & ~grant_q);
`else
  assign sel_win_s  = norm_win_s;
  assign sel_idx_s  = norm_idx_s;
  assign sel_mask_s = norm_mask_s;
  assign preempt_s  = 1'b0;
`endif

  assign last_s = valid_q & ((credit_q == CREDIT_ONE) | ~owner_req_s | preempt_s);

  // Next-state and next-output computation for the IDLE/GRANT machine.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    mask_d       = mask_q;
    owner_mask_d = owner_mask_q;
    valid_d      = valid_q;
    idx_d        = idx_q;
    credit_d     = credit_q;
    case (state_q)
      ST_IDLE: begin
        if (|req) begin
          state_d      = ST_GRANT;
          grant_d      = sel_win_s;
          idx_d        = sel_idx_s;
          valid_d      = 1'b1;
          credit_d     = fresh_credit(weight_s[sel_idx_s]);
          owner_mask_d = sel_mask_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (!grantAck) begin
          state_d = ST_GRANT;
        end else if (!last_s) begin
          credit_d = credit_q - CREDIT_ONE;
        end else begin
          mask_d = owner_mask_q;
          if (|sel_win_s) begin
            grant_d      = sel_win_s;
            idx_d        = sel_idx_s;
            credit_d     = fresh_credit(weight_s[sel_idx_s]);
            owner_mask_d = sel_mask_s;
          end else if (owner_req_s) begin
            credit_d = fresh_credit(weight_s[idx_q]);
          end else begin
            state_d  = ST_IDLE;
            grant_d  = NONE;
            idx_d    = {IDX_WIDTH{1'b0}};
            valid_d  = 1'b0;
            credit_d = {WEIGHT_WIDTH{1'b0}};
          end
        end
      end
      default: begin
        state_d  = ST_IDLE;
        grant_d  = NONE;
        idx_d    = {IDX_WIDTH{1'b0}};
        valid_d  = 1'b0;
        credit_d = {WEIGHT_WIDTH{1'b0}};
        mask_d   = ALL_ONES;
      end
    endcase
  end

  // Arbiter state and registered outputs.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      grant_q      <= NONE;
      mask_q       <= ALL_ONES;
      owner_mask_q <= ALL_ONES;
      valid_q      <= 1'b0;
      idx_q        <= {IDX_WIDTH{1'b0}};
      credit_q     <= {WEIGHT_WIDTH{1'b0}};
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      mask_q       <= mask_d;
      owner_mask_q <= owner_mask_d;
      valid_q      <= valid_d;
      idx_q        <= idx_d;
      credit_q     <= credit_d;
    end
  end

  assign grant      = grant_q;
  assign grantValid = valid_q;
  assign grantIdx   = idx_q;
  assign grantLast  = last_s;

endmodule
